// File: rtl/send_pattern_pkg.sv
// Shared types for the send_pattern traffic source: pattern modes and FSM states.
package send_pattern_pkg;

   typedef enum logic [1:0] {
      TOGGLE = 2'd0,
      INC    = 2'd1,
      LFSR   = 2'd2,
      CONST  = 2'd3
   } mode_e;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

endpackage

// File: rtl/send_pattern_dly.sv
// DEPTH-stage shift register; a handshake entering stage 0 emerges DEPTH cycles later.
module send_pattern_dly #(
   parameter int unsigned DEPTH = 11
) (
   input  logic clk,
   input  logic rst_n,
   input  logic hs,
   output logic xfer_dly
);

   logic [DEPTH-1:0] sr;

   generate
      if (DEPTH == 1) begin : g_one
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) sr <= '0;
            else        sr <= hs;
         end
      end else begin : g_multi
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) sr <= '0;
            else        sr <= {sr[DEPTH-2:0], hs};
         end
      end
   endgenerate

   assign xfer_dly = sr[DEPTH-1];

endmodule

// File: rtl/send_pattern.sv
// Programmable ready/valid word source: emits a bounded burst of TOGGLE/INC/LFSR/CONST words.
module send_pattern
   import send_pattern_pkg::*;
#(
   parameter int unsigned     WIDTH = 8,
   parameter int unsigned     CNT_W = 16,
   parameter int unsigned     DEPTH = 11,
   parameter int unsigned     STEP  = 1,
   parameter logic [WIDTH-1:0] TAPS = WIDTH'(8'hB8)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] seed,
   input  logic [CNT_W-1:0] count,
   output logic [WIDTH-1:0] ch_s,
   output logic             ch_s_vld,
   input  logic             ch_s_rdy,
   output logic             busy,
   output logic             done,
   output logic             xfer_dly
);

   state_e             state, state_nxt;
   mode_e              mode_q, mode_nxt;
   logic [WIDTH-1:0]   word, word_nxt, adv_c;
   logic [CNT_W-1:0]   rem, rem_nxt;
   logic               done_q, done_nxt;
   logic               hs_c;
   mode_e              mode_in_c;

   assign mode_in_c = mode_e'(mode);
   assign hs_c      = ch_s_vld & ch_s_rdy;

   // Next word in the latched pattern, modulo 2^WIDTH
   always_comb begin
      adv_c = word;
      case (mode_q)
         TOGGLE:  adv_c = ~word;
         INC:     adv_c = word + WIDTH'(STEP);
         LFSR:    adv_c = (word >> 1) ^ (word[0] ? TAPS : '0);
         CONST:   adv_c = word;
         default: adv_c = word;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         mode_q <= TOGGLE;
         word   <= '0;
         rem    <= '0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         mode_q <= mode_nxt;
         word   <= word_nxt;
         rem    <= rem_nxt;
         done_q <= done_nxt;
      end
   end

   // Burst control; an all-zero LFSR seed would lock up, so it is replaced by 1
   always_comb begin
      state_nxt = state;
      mode_nxt  = mode_q;
      word_nxt  = word;
      rem_nxt   = rem;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (count != '0) begin
                  state_nxt = SEND;
                  mode_nxt  = mode_in_c;
                  rem_nxt   = count;
                  word_nxt  = (mode_in_c == LFSR && seed == '0) ? WIDTH'(1) : seed;
               end else begin
                  done_nxt  = 1'b1;
               end
            end
         end
         SEND: begin
            if (hs_c) begin
               word_nxt = adv_c;
               rem_nxt  = rem - CNT_W'(1);
               if (rem == CNT_W'(1)) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign ch_s     = word;
   assign ch_s_vld = (state == SEND);
   assign busy     = (state == SEND);
   assign done     = done_q;

   send_pattern_dly #(.DEPTH(DEPTH)) u_dly (
      .clk      (clk),
      .rst_n    (rst_n),
      .hs       (hs_c),
      .xfer_dly (xfer_dly)
   );

endmodule

// File: tb/tb_send_pattern.sv
// Directed bench for send_pattern with hand-computed per-cycle expectations.
module tb_send_pattern;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [1:0]  mode;
   logic [7:0]  seed;
   logic [15:0] count;
   logic [7:0]  ch_s;
   logic        ch_s_vld;
   logic        ch_s_rdy;
   logic        busy;
   logic        done;
   logic        xfer_dly;

   int n_chk  = 0;
   int n_pass = 0;

   logic [7:0] exp_tog  [4] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
   logic [7:0] exp_inc  [5] = '{8'hFE, 8'hFF, 8'hFF, 8'h00, 8'h00};
   logic [7:0] exp_lfsr [3] = '{8'h01, 8'hB8, 8'h5C};

   send_pattern dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .mode     (mode),
      .seed     (seed),
      .count    (count),
      .ch_s     (ch_s),
      .ch_s_vld (ch_s_vld),
      .ch_s_rdy (ch_s_rdy),
      .busy     (busy),
      .done     (done),
      .xfer_dly (xfer_dly)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Sample start at the next edge; returns in the first cycle of the burst
   task automatic go(input logic [1:0] m, input logic [7:0] s, input logic [15:0] c);
      mode  = m;
      seed  = s;
      count = c;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      logic seen;
      rst_n    = 1'b0;
      start    = 1'b0;
      mode     = 2'd0;
      seed     = 8'h00;
      count    = 16'd0;
      ch_s_rdy = 1'b0;
      repeat (2) tick();
      chk("rst_ch_s", 32'(ch_s), 32'h0);
      chk("rst_vld",  32'(ch_s_vld), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_xfer", 32'(xfer_dly), 32'h0);
      rst_n = 1'b1;
      tick();

      // TOGGLE burst with xfer_dly timing
      ch_s_rdy = 1'b1;
      go(2'd0, 8'h00, 16'd4);
      for (int c = 1; c <= 16; c++) begin
         if (c <= 4) begin
            chk("tog_data", 32'(ch_s), 32'(exp_tog[c-1]));
            chk("tog_vld",  32'(ch_s_vld), 32'h1);
         end
         if (c == 5) chk("tog_vld_end", 32'(ch_s_vld), 32'h0);
         chk("tog_done", 32'(done), 32'(c == 5));
         chk("tog_xfer", 32'(xfer_dly), 32'(c >= 12 && c <= 15));
         if (c < 16) tick();
      end

      // INC with stalls and wrap
      ch_s_rdy = 1'b1;
      go(2'd1, 8'hFE, 16'd3);
      for (int c = 1; c <= 6; c++) begin
         ch_s_rdy = c[0];
         if (c <= 5) begin
            chk("inc_data", 32'(ch_s), 32'(exp_inc[c-1]));
            chk("inc_vld",  32'(ch_s_vld), 32'h1);
         end else begin
            chk("inc_vld_end", 32'(ch_s_vld), 32'h0);
         end
         chk("inc_done", 32'(done), 32'(c == 6));
         if (c < 6) tick();
      end

      // LFSR with zero seed
      ch_s_rdy = 1'b1;
      go(2'd2, 8'h00, 16'd3);
      for (int c = 1; c <= 4; c++) begin
         if (c <= 3) chk("lfsr_data", 32'(ch_s), 32'(exp_lfsr[c-1]));
         chk("lfsr_done", 32'(done), 32'(c == 4));
         if (c < 4) tick();
      end

      // count == 0
      go(2'd0, 8'h55, 16'd0);
      chk("zero_vld",  32'(ch_s_vld), 32'h0);
      chk("zero_busy", 32'(busy), 32'h0);
      chk("zero_done", 32'(done), 32'h1);
      tick();
      chk("zero_done_end", 32'(done), 32'h0);
      chk("zero_vld_end",  32'(ch_s_vld), 32'h0);

      // CONST with extra starts and input changes mid-burst
      mode  = 2'd3;
      seed  = 8'hA5;
      count = 16'd2;
      start = 1'b1;
      tick();
      mode  = 2'd0;
      seed  = 8'h3C;
      count = 16'd9;
      chk("const_w0", 32'(ch_s), 32'hA5);
      tick();
      chk("const_w1", 32'(ch_s), 32'hA5);
      chk("const_vld1", 32'(ch_s_vld), 32'h1);
      start = 1'b0;
      tick();
      chk("const_done", 32'(done), 32'h1);
      chk("const_vld_end", 32'(ch_s_vld), 32'h0);
      tick();
      chk("const_idle_vld",  32'(ch_s_vld), 32'h0);
      chk("const_idle_busy", 32'(busy), 32'h0);

      // Reset mid-burst
      ch_s_rdy = 1'b1;
      go(2'd1, 8'h10, 16'd5);
      chk("rb_w0", 32'(ch_s), 32'h10);
      tick();
      chk("rb_w1", 32'(ch_s), 32'h11);
      tick();
      chk("rb_w2", 32'(ch_s), 32'h12);
      rst_n = 1'b0;
      #1;
      chk("rb_ch_s", 32'(ch_s), 32'h0);
      chk("rb_vld",  32'(ch_s_vld), 32'h0);
      chk("rb_busy", 32'(busy), 32'h0);
      chk("rb_done", 32'(done), 32'h0);
      chk("rb_xfer", 32'(xfer_dly), 32'h0);
      repeat (3) tick();
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (15) begin
         tick();
         seen = seen | xfer_dly | ch_s_vld;
      end
      chk("rb_no_stale", 32'(seen), 32'h0);
      go(2'd1, 8'h20, 16'd1);
      chk("rb_fresh_data", 32'(ch_s), 32'h20);
      chk("rb_fresh_vld",  32'(ch_s_vld), 32'h1);
      tick();
      chk("rb_fresh_done", 32'(done), 32'h1);
      repeat (10) tick();
      chk("rb_fresh_xfer", 32'(xfer_dly), 32'h1);
      tick();
      chk("rb_fresh_xfer_end", 32'(xfer_dly), 32'h0);

      // Back-to-back bursts
      ch_s_rdy = 1'b1;
      go(2'd0, 8'h0F, 16'd1);
      chk("b2b_w0", 32'(ch_s), 32'h0F);
      tick();
      chk("b2b_done1", 32'(done), 32'h1);
      chk("b2b_gap_vld", 32'(ch_s_vld), 32'h0);
      go(2'd1, 8'h40, 16'd2);
      chk("b2b_vld2", 32'(ch_s_vld), 32'h1);
      chk("b2b_w1", 32'(ch_s), 32'h40);
      tick();
      chk("b2b_w2", 32'(ch_s), 32'h41);
      tick();
      chk("b2b_done2", 32'(done), 32'h1);
      chk("b2b_vld_end", 32'(ch_s_vld), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
